// File: rtl/dhcp_vlg_pkg.sv
// Shared types and constants for the DHCP client FSM and its lease timer.
package dhcp_vlg_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StDiscTx,
    StOfferWait,
    StReqTx,
    StAckWait,
    StBound,
    StRenewTx,
    StRenewWait,
    StFail
  } client_state_e;

  localparam logic [7:0] DHCP_MSG_TYPE_DISCOVER = 8'd1;
  localparam logic [7:0] DHCP_MSG_TYPE_OFFER    = 8'd2;
  localparam logic [7:0] DHCP_MSG_TYPE_REQUEST  = 8'd3;
  localparam logic [7:0] DHCP_MSG_TYPE_ACK      = 8'd5;
  localparam logic [7:0] DHCP_MSG_TYPE_NAK      = 8'd6;

  localparam logic [31:0] DHCP_LEASE_INFINITE = 32'hffff_ffff;
  localparam logic [31:0] DHCP_LEASE_MIN      = 32'd2;
  localparam logic [31:0] DHCP_BCAST_IP       = 32'hffff_ffff;

  // Very short leases would make T1 and expiry collapse onto the ACK cycle.
  function automatic logic [31:0] dhcp_lease_norm(input logic [31:0] lease);
    return (lease < DHCP_LEASE_MIN) ? DHCP_LEASE_MIN : lease;
  endfunction

endpackage

// File: rtl/dhcp_vlg_lease_timer.sv
// Lease seconds counter (prescaled from clk) with T1/expiry flags, plus the
// per-phase reply timeout down-counter.
module dhcp_vlg_lease_timer
  import dhcp_vlg_pkg::*;
#(
  parameter int unsigned TicksPerSec  = 125000000,
  parameter logic [31:0] TimeoutTicks = 32'd500000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lease_clr_i,
  input  logic        lease_run_i,
  input  logic [31:0] lease_i,
  output logic        lease_half_o,
  output logic        lease_exp_o,
  input  logic        to_load_i,
  input  logic        to_run_i,
  output logic        to_exp_o
);

  localparam logic [31:0] PreMax = 32'(TicksPerSec - 1);

  logic [31:0] pre_q, pre_d;
  logic [31:0] sec_q, sec_d;
  logic [31:0] to_q, to_d;
  logic        infinite;

  assign infinite = (lease_i == DHCP_LEASE_INFINITE);

  always_comb begin
    pre_d = pre_q;
    sec_d = sec_q;
    if (lease_clr_i) begin
      pre_d = '0;
      sec_d = '0;
    end else if (lease_run_i) begin
      if (pre_q >= PreMax) begin
        pre_d = '0;
        // Saturate so a long-running counter never wraps back under the lease.
        if (sec_q != '1) sec_d = sec_q + 32'd1;
      end else begin
        pre_d = pre_q + 32'd1;
      end
    end
  end

  always_comb begin
    to_d = to_q;
    if (to_load_i) begin
      to_d = TimeoutTicks;
    end else if (to_run_i && (to_q != '0)) begin
      to_d = to_q - 32'd1;
    end
  end

  assign lease_half_o = !infinite && (sec_q == (lease_i >> 1));
  assign lease_exp_o  = !infinite && (sec_q >= lease_i);
  assign to_exp_o     = to_run_i && (to_q <= 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      sec_q <= '0;
      to_q  <= '0;
    end else begin
      pre_q <= pre_d;
      sec_q <= sec_d;
      to_q  <= to_d;
    end
  end

endmodule

// File: rtl/dhcp_vlg_client.sv
// DHCP client: DISCOVER/OFFER/REQUEST/ACK with per-phase retries, lease
// tracking and T1 unicast renewal; drives the IPv4 address for the IP layer.
module dhcp_vlg_client
  import dhcp_vlg_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR      = 48'h0,
  parameter logic [31:0] XID_SEED      = 32'hdeadface,
  parameter int unsigned TICKS_PER_SEC = 125000000,
  parameter int unsigned TIMEOUT_SEC   = 4,
  parameter int unsigned RETRIES       = 3,
  parameter bit          RENEW_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx_val,
  input  logic [7:0]  rx_msg_type,
  input  logic [31:0] rx_xid,
  input  logic [31:0] rx_yiaddr,
  input  logic [31:0] rx_srv_id,
  input  logic [31:0] rx_lease,
  input  logic [31:0] rx_subnet,
  input  logic [31:0] rx_router,
  output logic        tx_val,
  input  logic        tx_rdy,
  output logic [7:0]  tx_msg_type,
  output logic [31:0] tx_xid,
  output logic [31:0] tx_req_ip,
  output logic [31:0] tx_srv_id,
  output logic [31:0] tx_ciaddr,
  output logic [31:0] tx_dst_ip,
  output logic [47:0] tx_chaddr,
  output logic [31:0] ipv4_addr,
  output logic [31:0] subnet_mask,
  output logic [31:0] router_ip,
  output logic        ipv4_addr_val,
  output logic        ok,
  output logic        timeout
);

  localparam logic [31:0] TimeoutTicks = 32'(TIMEOUT_SEC * TICKS_PER_SEC);

  client_state_e state_q, state_d;
  logic [31:0]   xid_q, xid_d;
  logic [7:0]    retry_q, retry_d;
  logic [31:0]   offer_ip_q, offer_ip_d;
  logic [31:0]   srv_q, srv_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   mask_q, mask_d;
  logic [31:0]   router_q, router_d;
  logic [31:0]   lease_q, lease_d;
  logic          addr_val_q, addr_val_d;
  logic          ok_q, ok_d;
  logic          timeout_q, timeout_d;

  logic rx_ok, is_offer, is_ack, is_nak, retry_left;
  logic lease_clr, lease_half, lease_exp_raw, lease_exp;
  logic to_load, to_run, to_exp;

  assign rx_ok      = rx_val && (rx_xid == xid_q);
  assign is_offer   = (rx_msg_type == DHCP_MSG_TYPE_OFFER);
  assign is_ack     = (rx_msg_type == DHCP_MSG_TYPE_ACK);
  assign is_nak     = (rx_msg_type == DHCP_MSG_TYPE_NAK);
  assign retry_left = 32'(retry_q) < RETRIES;
  assign to_run     = state_q inside {StOfferWait, StAckWait, StRenewWait};
  assign lease_exp  = lease_exp_raw && addr_val_q;

  dhcp_vlg_lease_timer #(
    .TicksPerSec  (TICKS_PER_SEC),
    .TimeoutTicks (TimeoutTicks)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .lease_clr_i  (lease_clr),
    .lease_run_i  (addr_val_q),
    .lease_i      (lease_q),
    .lease_half_o (lease_half),
    .lease_exp_o  (lease_exp_raw),
    .to_load_i    (to_load),
    .to_run_i     (to_run),
    .to_exp_o     (to_exp)
  );

  // Transmit request fields; all zero outside the *_TX states.
  always_comb begin
    tx_val      = 1'b0;
    tx_msg_type = '0;
    tx_xid      = '0;
    tx_req_ip   = '0;
    tx_srv_id   = '0;
    tx_ciaddr   = '0;
    tx_dst_ip   = '0;
    tx_chaddr   = '0;
    unique case (state_q)
      StDiscTx: begin
        tx_val      = 1'b1;
        tx_msg_type = DHCP_MSG_TYPE_DISCOVER;
        tx_xid      = xid_q;
        tx_dst_ip   = DHCP_BCAST_IP;
        tx_chaddr   = MAC_ADDR;
      end
      StReqTx: begin
        tx_val      = 1'b1;
        tx_msg_type = DHCP_MSG_TYPE_REQUEST;
        tx_xid      = xid_q;
        tx_req_ip   = offer_ip_q;
        tx_srv_id   = srv_q;
        tx_dst_ip   = DHCP_BCAST_IP;
        tx_chaddr   = MAC_ADDR;
      end
      StRenewTx: begin
        tx_val      = 1'b1;
        tx_msg_type = DHCP_MSG_TYPE_REQUEST;
        tx_xid      = xid_q;
        tx_ciaddr   = addr_q;
        tx_dst_ip   = srv_q;
        tx_chaddr   = MAC_ADDR;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    xid_d      = xid_q;
    retry_d    = retry_q;
    offer_ip_d = offer_ip_q;
    srv_d      = srv_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    router_d   = router_q;
    lease_d    = lease_q;
    addr_val_d = addr_val_q && !lease_exp;
    ok_d       = 1'b0;
    timeout_d  = 1'b0;
    lease_clr  = 1'b0;
    to_load    = 1'b0;

    case (state_q)
      StIdle, StFail: begin
        if (start) begin
          state_d = StDiscTx;
          retry_d = '0;
          if (state_q == StFail) xid_d = xid_q + 32'd1;
        end
      end

      StDiscTx, StReqTx, StRenewTx: begin
        if ((state_q == StRenewTx) && lease_exp) begin
          state_d = StDiscTx;
          xid_d   = xid_q + 32'd1;
          retry_d = '0;
        end else if (tx_rdy) begin
          to_load = 1'b1;
          retry_d = retry_q + 8'd1;
          if (state_q == StDiscTx)     state_d = StOfferWait;
          else if (state_q == StReqTx) state_d = StAckWait;
          else                         state_d = StRenewWait;
        end
      end

      StOfferWait: begin
        if (rx_ok && is_offer) begin
          offer_ip_d = rx_yiaddr;
          srv_d      = rx_srv_id;
          retry_d    = '0;
          state_d    = StReqTx;
        end else if (to_exp) begin
          if (retry_left) begin
            state_d = StDiscTx;
          end else begin
            state_d    = StFail;
            timeout_d  = 1'b1;
            addr_val_d = 1'b0;
          end
        end
      end

      StAckWait, StRenewWait: begin
        if (rx_ok && is_ack) begin
          addr_d     = rx_yiaddr;
          mask_d     = rx_subnet;
          router_d   = rx_router;
          lease_d    = dhcp_lease_norm(rx_lease);
          // An ACK without option 54 keeps the server we already know.
          srv_d      = (rx_srv_id != '0) ? rx_srv_id : srv_q;
          addr_val_d = 1'b1;
          ok_d       = 1'b1;
          lease_clr  = 1'b1;
          retry_d    = '0;
          state_d    = StBound;
        end else if (rx_ok && is_nak) begin
          addr_val_d = 1'b0;
          xid_d      = xid_q + 32'd1;
          retry_d    = '0;
          state_d    = StDiscTx;
        end else if ((state_q == StRenewWait) && lease_exp) begin
          xid_d   = xid_q + 32'd1;
          retry_d = '0;
          state_d = StDiscTx;
        end else if (to_exp) begin
          if (retry_left) begin
            state_d = (state_q == StAckWait) ? StReqTx : StRenewTx;
          end else if (state_q == StRenewWait) begin
            // Renewal gave up: rediscover but keep the address until it expires.
            xid_d   = xid_q + 32'd1;
            retry_d = '0;
            state_d = StDiscTx;
          end else begin
            state_d    = StFail;
            timeout_d  = 1'b1;
            addr_val_d = 1'b0;
          end
        end
      end

      StBound: begin
        if (lease_exp) begin
          xid_d   = xid_q + 32'd1;
          retry_d = '0;
          state_d = StDiscTx;
        end else if (RENEW_EN && lease_half) begin
          xid_d   = xid_q + 32'd1;
          retry_d = '0;
          state_d = StRenewTx;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      xid_q      <= XID_SEED;
      retry_q    <= '0;
      offer_ip_q <= '0;
      srv_q      <= '0;
      addr_q     <= '0;
      mask_q     <= '0;
      router_q   <= '0;
      lease_q    <= '0;
      addr_val_q <= 1'b0;
      ok_q       <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      xid_q      <= xid_d;
      retry_q    <= retry_d;
      offer_ip_q <= offer_ip_d;
      srv_q      <= srv_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      router_q   <= router_d;
      lease_q    <= lease_d;
      addr_val_q <= addr_val_d;
      ok_q       <= ok_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ipv4_addr     = addr_q;
  assign subnet_mask   = mask_q;
  assign router_ip     = router_q;
  assign ipv4_addr_val = addr_val_q && !lease_exp;
  assign ok            = ok_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_dhcp_vlg_client.sv
// Directed bench for dhcp_vlg_client: 10 ticks per second, 10 s reply timeout.
`timescale 1ns/1ps
module tb_dhcp_vlg_client;

  localparam logic [47:0] Mac  = 48'h02_00_5e_00_00_01;
  localparam logic [31:0] Yi   = 32'hc0a8_0132;
  localparam logic [31:0] Srv  = 32'hc0a8_0101;
  localparam logic [31:0] Mask = 32'hffff_ff00;
  localparam logic [31:0] Gw   = 32'hc0a8_01fe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_val = 1'b0;
  logic [7:0]  rx_msg_type = '0;
  logic [31:0] rx_xid = '0, rx_yiaddr = '0, rx_srv_id = '0, rx_lease = '0;
  logic [31:0] rx_subnet = '0, rx_router = '0;
  logic        tx_val, tx_rdy = 1'b0;
  logic [7:0]  tx_msg_type;
  logic [31:0] tx_xid, tx_req_ip, tx_srv_id, tx_ciaddr, tx_dst_ip;
  logic [47:0] tx_chaddr;
  logic [31:0] ipv4_addr, subnet_mask, router_ip;
  logic        ipv4_addr_val, ok, timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dhcp_vlg_client #(
    .MAC_ADDR      (Mac),
    .XID_SEED      (32'hdeadface),
    .TICKS_PER_SEC (10),
    .TIMEOUT_SEC   (10),
    .RETRIES       (3),
    .RENEW_EN      (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .rx_val        (rx_val),
    .rx_msg_type   (rx_msg_type),
    .rx_xid        (rx_xid),
    .rx_yiaddr     (rx_yiaddr),
    .rx_srv_id     (rx_srv_id),
    .rx_lease      (rx_lease),
    .rx_subnet     (rx_subnet),
    .rx_router     (rx_router),
    .tx_val        (tx_val),
    .tx_rdy        (tx_rdy),
    .tx_msg_type   (tx_msg_type),
    .tx_xid        (tx_xid),
    .tx_req_ip     (tx_req_ip),
    .tx_srv_id     (tx_srv_id),
    .tx_ciaddr     (tx_ciaddr),
    .tx_dst_ip     (tx_dst_ip),
    .tx_chaddr     (tx_chaddr),
    .ipv4_addr     (ipv4_addr),
    .subnet_mask   (subnet_mask),
    .router_ip     (router_ip),
    .ipv4_addr_val (ipv4_addr_val),
    .ok            (ok),
    .timeout       (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; rx_val = 1'b0; tx_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_rx(input logic [7:0] t, input logic [31:0] x, input logic [31:0] lease);
    rx_msg_type = t; rx_xid = x; rx_yiaddr = Yi; rx_srv_id = Srv; rx_lease = lease;
    rx_subnet = Mask; rx_router = Gw; rx_val = 1'b1;
    tick();
    rx_val = 1'b0;
  endtask

  task automatic handshake();
    tx_rdy = 1'b1;
    tick();
    tx_rdy = 1'b0;
  endtask

  // Full acquisition with xid deadface; returns right after the ACK edge.
  task automatic bring_up(input logic [31:0] lease);
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    handshake();
    send_rx(8'd2, 32'hdeadface, lease);
    handshake();
    send_rx(8'd5, 32'hdeadface, lease);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; tx_rdy = 1'b1;
    #1;
    checks++; if (tx_val !== 1'b0) begin failures++; $display("FAIL reset_tx_val got=%0b exp=0", tx_val); end
    checks++; if (ipv4_addr_val !== 1'b0 || ok !== 1'b0 || timeout !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%0b%0b%0b exp=000", ipv4_addr_val, ok, timeout); end
    checks++; if (tx_xid !== 32'h0 || ipv4_addr !== 32'h0) begin
      failures++; $display("FAIL reset_values got=%h/%h exp=0/0", tx_xid, ipv4_addr); end
    start = 1'b0; tx_rdy = 1'b0;
    tick(); rst_n = 1'b1; tick();
    checks++; if (tx_val !== 1'b0) begin failures++; $display("FAIL idle_tx_val got=%0b exp=0", tx_val); end
  endtask

  task automatic test_acquire();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (tx_val !== 1'b1 || tx_msg_type !== 8'd1 || tx_xid !== 32'hdeadface) begin
      failures++; $display("FAIL disc_fields got=%0b/%0d/%h exp=1/1/deadface", tx_val, tx_msg_type, tx_xid); end
    checks++; if (tx_dst_ip !== 32'hffffffff || tx_req_ip !== 32'h0 || tx_chaddr !== Mac) begin
      failures++; $display("FAIL disc_addr got=%h/%h/%h", tx_dst_ip, tx_req_ip, tx_chaddr); end
    handshake();
    checks++; if (tx_val !== 1'b0) begin failures++; $display("FAIL disc_drop got=%0b exp=0", tx_val); end
    send_rx(8'd2, 32'hdeadface, 32'd100);
    checks++; if (tx_val !== 1'b1 || tx_msg_type !== 8'd3 || tx_xid !== 32'hdeadface) begin
      failures++; $display("FAIL req_fields got=%0b/%0d/%h exp=1/3/deadface", tx_val, tx_msg_type, tx_xid); end
    checks++; if (tx_req_ip !== Yi || tx_srv_id !== Srv || tx_ciaddr !== 32'h0
                  || tx_dst_ip !== 32'hffffffff) begin
      failures++; $display("FAIL req_addr got=%h/%h/%h/%h exp=%h/%h/0/ffffffff",
                           tx_req_ip, tx_srv_id, tx_ciaddr, tx_dst_ip, Yi, Srv); end
    handshake();
    send_rx(8'd5, 32'hdeadface, 32'd100);
    checks++; if (ok !== 1'b1 || ipv4_addr_val !== 1'b1) begin
      failures++; $display("FAIL ack_ok got=%0b/%0b exp=1/1", ok, ipv4_addr_val); end
    checks++; if (ipv4_addr !== Yi || subnet_mask !== Mask || router_ip !== Gw) begin
      failures++; $display("FAIL ack_addr got=%h/%h/%h", ipv4_addr, subnet_mask, router_ip); end
    tick();
    checks++; if (ok !== 1'b0 || ipv4_addr_val !== 1'b1) begin
      failures++; $display("FAIL ok_pulse got=%0b/%0b exp=0/1", ok, ipv4_addr_val); end
  endtask

  task automatic test_bad_xid();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    handshake();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (tx_val !== 1'b0) begin failures++; $display("FAIL start_ignored got=%0b exp=0", tx_val); end
    send_rx(8'd2, 32'hdeadfac0, 32'd100);
    repeat (5) tick();
    checks++; if (tx_val !== 1'b0) begin failures++; $display("FAIL bad_xid got=%0b exp=0", tx_val); end
    send_rx(8'd2, 32'hdeadface, 32'd100);
    checks++; if (tx_val !== 1'b1 || tx_msg_type !== 8'd3 || tx_req_ip !== Yi) begin
      failures++; $display("FAIL good_offer got=%0b/%0d/%h exp=1/3/%h", tx_val, tx_msg_type, tx_req_ip, Yi); end
  endtask

  task automatic test_timeout();
    int n, t, last;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    t = 0; last = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!tx_val && n < 200) begin tick(); n++; t++; end
      checks++; if (tx_val !== 1'b1 || tx_msg_type !== 8'd1 || tx_xid !== 32'hdeadface) begin
        failures++; $display("FAIL retry_disc%0d got=%0b/%0d/%h exp=1/1/deadface", i, tx_val, tx_msg_type, tx_xid); end
      if (i > 0) begin
        checks++; if (t - last < 100 || t - last > 102) begin
          failures++; $display("FAIL retry_gap%0d got=%0d exp=100..102", i, t - last); end
      end
      last = t;
      handshake(); t++;
    end
    n = 0;
    while (!timeout && n < 200) begin tick(); n++; end
    checks++; if (timeout !== 1'b1 || n < 99 || n > 101) begin
      failures++; $display("FAIL timeout_pulse got=%0b@%0d exp=1@100", timeout, n); end
    tick();
    checks++; if (timeout !== 1'b0 || tx_val !== 1'b0) begin
      failures++; $display("FAIL fail_hold got=%0b/%0b exp=0/0", timeout, tx_val); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (tx_val !== 1'b1 || tx_xid !== 32'hdeadfacf) begin
      failures++; $display("FAIL restart_xid got=%0b/%h exp=1/deadfacf", tx_val, tx_xid); end
  endtask

  task automatic test_renew();
    int n;
    bring_up(32'd10);
    n = 0;
    while (!tx_val && n < 200) begin tick(); n++; end
    checks++; if (n < 50 || n > 52 || tx_msg_type !== 8'd3 || tx_xid !== 32'hdeadfacf) begin
      failures++; $display("FAIL renew_req got=%0d/%0d/%h exp=51/3/deadfacf", n, tx_msg_type, tx_xid); end
    checks++; if (tx_ciaddr !== Yi || tx_dst_ip !== Srv || tx_req_ip !== 32'h0 || tx_srv_id !== 32'h0) begin
      failures++; $display("FAIL renew_addr got=%h/%h/%h/%h exp=%h/%h/0/0",
                           tx_ciaddr, tx_dst_ip, tx_req_ip, tx_srv_id, Yi, Srv); end
    handshake();
    send_rx(8'd5, 32'hdeadfacf, 32'd10);
    checks++; if (ok !== 1'b1 || ipv4_addr_val !== 1'b1) begin
      failures++; $display("FAIL renew_ack got=%0b/%0b exp=1/1", ok, ipv4_addr_val); end
    n = 0;
    while (!tx_val && n < 200) begin tick(); n++; end
    checks++; if (n < 50 || n > 52 || tx_xid !== 32'hdeadfad0) begin
      failures++; $display("FAIL renew2_req got=%0d/%h exp=51/deadfad0", n, tx_xid); end
    handshake(); n++;
    while (ipv4_addr_val && n < 300) begin tick(); n++; end
    checks++; if (ipv4_addr_val !== 1'b0 || n < 99 || n > 101) begin
      failures++; $display("FAIL lease_expiry got=%0b@%0d exp=0@100", ipv4_addr_val, n); end
    tick();
    checks++; if (tx_val !== 1'b1 || tx_msg_type !== 8'd1 || tx_xid !== 32'hdeadfad1) begin
      failures++; $display("FAIL expiry_disc got=%0b/%0d/%h exp=1/1/deadfad1", tx_val, tx_msg_type, tx_xid); end
  endtask

  task automatic test_nak();
    int n;
    bring_up(32'd10);
    n = 0;
    while (!tx_val && n < 200) begin tick(); n++; end
    handshake();
    checks++; if (ipv4_addr_val !== 1'b1) begin
      failures++; $display("FAIL pre_nak_val got=%0b exp=1", ipv4_addr_val); end
    send_rx(8'd6, 32'hdeadfacf, 32'd0);
    checks++; if (ipv4_addr_val !== 1'b0) begin
      failures++; $display("FAIL nak_val got=%0b exp=0", ipv4_addr_val); end
    checks++; if (tx_val !== 1'b1 || tx_msg_type !== 8'd1 || tx_xid !== 32'hdeadfad0) begin
      failures++; $display("FAIL nak_disc got=%0b/%0d/%h exp=1/1/deadfad0", tx_val, tx_msg_type, tx_xid); end
  endtask

  task automatic test_lease_bounds();
    int n;
    bring_up(32'd0);
    n = 0;
    while (!tx_val && n < 200) begin tick(); n++; end
    checks++; if (n < 10 || n > 12 || tx_msg_type !== 8'd3) begin
      failures++; $display("FAIL min_lease_renew got=%0d/%0d exp=11/3", n, tx_msg_type); end
    bring_up(32'hffffffff);
    repeat (400) tick();
    checks++; if (tx_val !== 1'b0 || ipv4_addr_val !== 1'b1) begin
      failures++; $display("FAIL infinite_lease got=%0b/%0b exp=0/1", tx_val, ipv4_addr_val); end
  endtask

  task automatic test_reset_mid();
    int n;
    bring_up(32'd10);
    n = 0;
    while (!tx_val && n < 200) begin tick(); n++; end
    handshake();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ipv4_addr_val !== 1'b0 || ipv4_addr !== 32'h0 || subnet_mask !== 32'h0
                  || router_ip !== 32'h0) begin
      failures++; $display("FAIL async_reset got=%0b/%h/%h/%h exp=0/0/0/0",
                           ipv4_addr_val, ipv4_addr, subnet_mask, router_ip); end
    tick(); rst_n = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    handshake();
    send_rx(8'd2, 32'hdeadface, 32'd100);
    handshake();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_val !== 1'b0 || ok !== 1'b0 || timeout !== 1'b0 || tx_xid !== 32'h0) begin
      failures++; $display("FAIL ackwait_reset got=%0b/%0b/%0b/%h exp=0/0/0/0", tx_val, ok, timeout, tx_xid); end
    tick(); rst_n = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (tx_val !== 1'b1 || tx_xid !== 32'hdeadface) begin
      failures++; $display("FAIL post_reset_idle got=%0b/%h exp=1/deadface", tx_val, tx_xid); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_bad_xid();
    test_timeout();
    test_renew();
    test_nak();
    test_lease_bounds();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dhcp_vlg_client.md
Name: dhcp_vlg_client

Overview:
Parametrised DHCP client FSM replacing the single-shot discover/offer core.
- Runs full DISCOVER/OFFER/REQUEST/ACK with per-phase timeout and bounded retries.
- Tracks the lease and renews at T1 by unicast REQUEST; restarts discovery on NAK, failed renewal or expiry.
- Sits between the UDP/DHCP parser (rx) and the DHCP packet generator (tx); drives the IPv4 address used by the IP layer.

Parameters:
MAC_ADDR, 48'h0, client hardware address placed in chaddr.
XID_SEED, 32'hdeadface, initial transaction ID; incremented by 1 per new transaction.
TICKS_PER_SEC, 125000000, clk cycles per lease second.
TIMEOUT_SEC, 4, seconds to wait for OFFER/ACK before retry.
RETRIES, 3, transmissions per phase before declaring timeout (≥1).
RENEW_EN, 1, 1 enables T1 renewal; 0 lets the lease expire and rediscovers.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin acquisition from IDLE or FAIL
rx_val  in  1  one-cycle strobe: parsed DHCP reply valid
rx_msg_type  in  8  option 53 value (2 OFFER, 5 ACK, 6 NAK)
rx_xid  in  32  reply transaction ID
rx_yiaddr  in  32  offered/assigned address
rx_srv_id  in  32  option 54 server identifier
rx_lease  in  32  option 51 lease time, seconds
rx_subnet  in  32  option 1
rx_router  in  32  option 3
tx_val  out  1  request to send; held until tx_rdy
tx_rdy  in  1  generator accepted frame
tx_msg_type  out  8  1 DISCOVER, 3 REQUEST
tx_xid  out  32  transaction ID
tx_req_ip  out  32  option 50 value (0 when not sent)
tx_srv_id  out  32  option 54 value (0 when not sent)
tx_ciaddr  out  32  ciaddr field (nonzero only in RENEW)
tx_dst_ip  out  32  255.255.255.255, or server IP in RENEW
ipv4_addr  out  32  bound address
subnet_mask  out  32  bound mask
router_ip  out  32  bound gateway
ipv4_addr_val  out  1  address valid (BOUND/RENEW states)
ok  out  1  one-cycle pulse on each successful ACK
timeout  out  1  one-cycle pulse on entering FAIL

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; all outputs 0; xid = XID_SEED; counters 0.
- States: IDLE, DISC_TX, OFFER_WAIT, REQ_TX, ACK_WAIT, BOUND, RENEW_TX, RENEW_WAIT, FAIL.
- IDLE/FAIL: start -> DISC_TX, retry count cleared.
- *_TX: tx_val=1 with fields stable; on tx_val&tx_rdy, tx_val drops the next cycle, timeout counter loads TIMEOUT_SEC*TICKS_PER_SEC, go to matching *_WAIT. Retry count increments per transmission.
- Reply acceptance requires rx_val and rx_xid==tx_xid; otherwise ignored, timer keeps running.
- OFFER_WAIT: OFFER -> latch yiaddr/srv_id, REQ_TX (retry count cleared; same xid, req_ip=yiaddr, srv_id set, ciaddr=0, broadcast). Other types ignored.
- ACK_WAIT/RENEW_WAIT: ACK -> latch addr/mask/router/lease, ok pulse, BOUND. NAK -> ipv4_addr_val=0, xid+1, DISC_TX.
- Timer expiry in a WAIT: if retry count<RETRIES re-enter the same *_TX; else FAIL with timeout pulse and ipv4_addr_val=0. Exception: RENEW_WAIT exhaustion -> xid+1, DISC_TX (address kept until lease expiry).
- BOUND: seconds counter runs from 0. At elapsed==lease>>1 with RENEW_EN -> RENEW_TX (new xid, ciaddr=ipv4_addr, unicast to srv_id, req_ip=0, srv_id=0).
- Lease expiry (elapsed≥lease) in any bound/renew/discover-after-renew state clears ipv4_addr_val in that cycle.
- Lease 0xFFFFFFFF = infinite: no renewal, no expiry. Lease 0 or 1: treated as 2 s minimum.
- Simultaneous rx accept and timer expiry: reply wins.
- start while not IDLE/FAIL: ignored.
- xid wraps modulo 2^32.

Decomposition:
- dhcp_vlg_pkg gains: client state enum, DHCP_MSG_TYPE_NAK, DHCP_LEASE_INFINITE, DHCP_BCAST_IP.
- Sub-module dhcp_vlg_lease_timer: prescaler plus 32-bit seconds counter with load/clear, half-lease and expiry flags, and the phase timeout down-counter.

Test Plan:
- start, offer yiaddr 192.168.1.50 srv 192.168.1.1 lease 100, then ACK -> DISCOVER xid deadface, REQUEST req_ip C0A80132, ok pulse, ipv4_addr_val=1.
- Reply with xid deadfac0 -> ignored; correct OFFER afterwards -> REQ_TX.
- No OFFER, RETRIES=3, TIMEOUT_SEC=1, TICKS_PER_SEC=100 -> 3 DISCOVERs spaced ≥100 cycles, then timeout pulse, state FAIL.
- NAK after REQUEST -> ipv4_addr_val=0, DISCOVER with xid deadfad0.
- Bound lease 10, TICKS_PER_SEC=10 -> unicast REQUEST at 50 cycles with ciaddr set; ACK -> ok, timer restarts; withhold replies -> ipv4_addr_val drops at 100 cycles.
- Assert rst_n low mid-ACK_WAIT -> all outputs 0 immediately; state IDLE.
